pipe_seg_skid: RTL and testbench
================================

Name: pipe_seg_skid

Overview:
Generic, parametrised pipeline segment register that replaces the fixed per-stage segment registers (if/id, id/ex, ex/mem, mem/wb). The flat stage payload is carried as one WIDTH-bit bus. Adds a valid/ready handshake and a one-entry skid buffer, so upstream can run at full throughput even though the downstream ready is registered. Keeps the existing stall (freeze) and refresh (flush) controls, and reports occupancy for the hazard unit.

Parameters:
WIDTH, 32, payload width in bits (whole packed stage bundle; any value ≥1).
CLEAR_DATA, 1, 1: data registers are zeroed on reset/refresh; 0: data registers hold their value and only the valid bits clear.

Ports:
clk  in  1  clock, all state updates on rising edge.
resetn  in  1  synchronous, active-low reset.
stall  in  1  freeze: no transfer in or out, contents held.
refresh  in  1  synchronous flush: discard all held entries.
in_valid  in  1  upstream has a payload.
in_ready  out  1  segment accepts a payload this cycle.
in_data  in  WIDTH  upstream payload.
out_valid  out  1  segment presents a payload.
out_ready  in  1  downstream accepts this cycle.
out_data  out  WIDTH  presented payload (= main register).
occ  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main (main_v, main_d) and skid (skid_v, skid_d). States: EMPTY (occ=0), ONE (main_v=1, skid_v=0), FULL (both valid). occ is derived from the state; skid_v=1 implies main_v=1.
- Combinational outputs:
  - in_ready = !skid_v && !stall && !refresh.
  - out_valid = main_v && !stall && !refresh.
  - out_data = main_d.
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Priority per edge: reset > refresh > stall > normal.
- Reset (resetn=0): main_v=skid_v=0, occ=0. If CLEAR_DATA=1, main_d=skid_d=0. Resulting outputs: in_ready=1 (if stall=0), out_valid=0, out_data=0.
- Refresh: same register effect as reset. No handshake completes that cycle because both readies/valids are gated. in_data offered during refresh is not taken; upstream must re-present it.
- Stall (refresh=0): all registers hold. in_ready=0, out_valid=0.
- Normal transitions:
  - EMPTY: in_fire -> main<=in_data, ONE.
  - ONE, in_fire && out_fire -> main<=in_data, stay ONE (full throughput, 1 payload/cycle).
  - ONE, in_fire only -> skid<=in_data, FULL.
  - ONE, out_fire only -> EMPTY (main_d zeroed only if CLEAR_DATA=1).
  - ONE, neither -> hold.
  - FULL: in_ready=0. out_fire -> main<=skid_d, skid_v=0, ONE. No out_fire -> hold.
- Latency: payload accepted at edge N is visible on out_data after edge N (one cycle) when the segment was EMPTY or draining. Otherwise ordering is strictly FIFO.
- No payload is ever lost or duplicated except by refresh/reset.
- out_data must not change while out_valid=1 and out_ready=0.
- in_ready depends on stall/refresh combinationally, never on out_ready (no ready combinational path through the segment).

Test Plan:
- Reset: resetn=0 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=0, occ=0; after release in_ready=1.
- Streaming: out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later, occ stays 1, in_ready always 1.
- Backpressure/skid: out_ready=0, push 0xA then 0xB -> occ=2, in_ready=0, 0xC held off. Raise out_ready -> outputs 0xA, 0xB, 0xC in order, none lost.
- Stall: occ=1 holding 0x55, stall=1 for 3 cycles with in_valid=1, out_ready=1 -> out_valid=0, in_ready=0, occ=1. After stall=0, 0x55 appears, then the new input.
- Refresh: occ=2 (0x11, 0x22), refresh=1 with in_valid=1, in_data=0x33 -> next cycle occ=0, out_valid=0, out_data=0 (CLEAR_DATA=1). 0x33 not captured.
- Simultaneous events: resetn=0 with refresh=1 and stall=1 -> reset result. Stall=1 with refresh=1 from FULL -> occ=0 next cycle. CLEAR_DATA=0 build: out_data retains the last value after refresh while out_valid=0.

Source files
------------

// File: rtl/pipe_seg_skid.sv
// Pipeline segment register with a valid/ready handshake and a one-entry skid buffer.
// Main holds the presented payload; skid catches the one accepted while downstream stalls.
module pipe_seg_skid #(
   parameter int WIDTH      = 32,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             stall,
   input  logic             refresh,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occ
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] main_d, skid_d;
   logic             main_v, skid_v;
   logic             in_fire, out_fire;
   logic             load_main_in, load_main_skid, load_skid, clr_main;

   assign main_v    = (state == ONE) || (state == FULL);
   assign skid_v    = (state == FULL);
   assign in_ready  = !skid_v && !stall && !refresh;
   assign out_valid = main_v && !stall && !refresh;
   assign out_data  = main_d;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!resetn || refresh) begin
         state <= EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   // Stall needs no branch here: both fires are already gated by it.
   always_comb begin
      state_nx       = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clr_main       = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               load_main_in = 1'b1;
               state_nx     = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_nx  = FULL;
            end else if (out_fire) begin
               clr_main = 1'b1;
               state_nx = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               load_main_skid = 1'b1;
               state_nx       = ONE;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn || refresh) begin
         if (CLEAR_DATA) begin
            main_d <= '0;
            skid_d <= '0;
         end
      end else begin
         if (load_main_in) begin
            main_d <= in_data;
         end else if (load_main_skid) begin
            main_d <= skid_d;
         end else if (clr_main && CLEAR_DATA) begin
            main_d <= '0;
         end
         if (load_skid) begin
            skid_d <= in_data;
         end
      end
   end

   always_comb begin
      case (state)
         ONE:     occ = 2'd1;
         FULL:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Scoreboard bench for pipe_seg_skid: a queue of accepted-but-undelivered payloads is the
// reference; a CLEAR_DATA=0 instance shares the inputs and must retain its last main value.
module tb_pipe_seg_skid;

   logic        clk = 1'b0;
   logic        resetn, stall, refresh, in_valid, out_ready;
   logic [31:0] in_data;
   logic        in_ready, out_valid, nc_in_ready, nc_out_valid;
   logic [31:0] out_data, nc_out_data;
   logic [1:0]  occ, nc_occ;

   int          vectors = 0;
   int          miscompares = 0;
   logic        chk_en = 1'b0;
   logic [31:0] q[$];
   logic [31:0] nc_last = '0;
   logic        nc_known = 1'b0;
   int          m_n;
   logic [31:0] m_hd;

   always #5 clk = ~clk;

   pipe_seg_skid #(.WIDTH(32), .CLEAR_DATA(1'b1)) dut (
      .clk(clk), .resetn(resetn), .stall(stall), .refresh(refresh),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occ(occ)
   );

   pipe_seg_skid #(.WIDTH(32), .CLEAR_DATA(1'b0)) dut_nc (
      .clk(clk), .resetn(resetn), .stall(stall), .refresh(refresh),
      .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data),
      .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data), .occ(nc_occ)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: mid-cycle, the queue holds exactly what the segment should contain.
   always @(negedge clk) begin
      if (chk_en) begin
         m_n  = q.size();
         m_hd = (m_n > 0) ? q[0] : 32'h0;
         chk("occ", 32'(occ), 32'(m_n));
         chk("in_ready", 32'(in_ready), 32'(m_n < 2 && !stall && !refresh));
         chk("out_valid", 32'(out_valid), 32'(m_n > 0 && !stall && !refresh));
         chk("out_data", out_data, m_hd);
         chk("nc_occ", 32'(nc_occ), 32'(m_n));
         chk("nc_in_ready", 32'(nc_in_ready), 32'(m_n < 2 && !stall && !refresh));
         chk("nc_out_valid", 32'(nc_out_valid), 32'(m_n > 0 && !stall && !refresh));
         if (m_n > 0) begin
            chk("nc_out_data", nc_out_data, q[0]);
            nc_last  = q[0];
            nc_known = 1'b1;
         end else if (nc_known) begin
            chk("nc_retained", nc_out_data, nc_last);
         end
         if (!resetn || refresh) begin
            q.delete();
         end else if (out_valid && out_ready && m_n > 0) begin
            chk("pop_data", out_data, q.pop_front());
         end
      end
   end

   // Stimulus logger: every payload the segment takes becomes an expected output.
   always @(negedge clk) begin
      #1;
      if (chk_en && resetn && !refresh && in_valid && in_ready) q.push_back(in_data);
   end

   task automatic drive(input logic rn, input logic st, input logic rf,
                        input logic iv, input logic [31:0] d, input logic ordy);
      @(posedge clk);
      #1;
      resetn = rn; stall = st; refresh = rf; in_valid = iv; in_data = d; out_ready = ordy;
   endtask

   task automatic send(input logic [31:0] d, input logic ordy);
      bit done = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b1, d, ordy);
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         else begin @(posedge clk); #1; end
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL send_timeout: payload %h not accepted, required acceptance", d);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit empty = 1'b0;
      out_ready = 1'b1; in_valid = 1'b0; stall = 1'b0; refresh = 1'b0; resetn = 1'b1;
      for (int i = 0; i < 20 && !empty; i++) begin
         @(posedge clk);
         #1;
         if (q.size() == 0) empty = 1'b1;
      end
      vectors++;
      if (!empty) begin
         miscompares++;
         $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      resetn = 1'b0; stall = 1'b0; refresh = 1'b0;
      in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Streaming at full throughput
      for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
      drain();

      // Backpressure into the skid, third payload held off
      send(32'hA, 1'b0);
      send(32'hB, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
      send(32'hC, 1'b1);
      drain();

      // Stall with one entry held
      send(32'h55, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h66, 1'b1);
      send(32'h66, 1'b1);
      drain();

      // Refresh from FULL, offered payload discarded
      send(32'h11, 1'b0);
      send(32'h22, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Reset beats refresh and stall; refresh beats stall
      send(32'h77, 1'b0);
      send(32'h88, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h99, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      send(32'hAA, 1'b0);
      send(32'hBB, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hCC, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drain();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(99) >= 2), ($urandom_range(99) < 10), ($urandom_range(99) < 3),
               ($urandom_range(99) < 70), $urandom, ($urandom_range(99) < 60));
      end
      drain();

      @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
